rx_arp: RTL and testbench

//  ARP receive parser. Takes the 16-bit Ethernet frame stream from the MAC receive path,

---
 rtl/rx_arp.sv | 240 ++++++++++++++++++++++++
 tb/tb_rx_arp.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_arp.sv
// rtl/rx_arp.sv - ARP receive parser for a 16-bit Ethernet frame stream
//
// Purpose:
//   Parses each received Ethernet frame word by word. ARP requests aimed at
//   the local IP produce a one-cycle ack_en_o pulse with the requester's
//   MAC/IP; ARP replies from the configured peer produce a one-cycle
//   arp_mac_vld_o pulse with the learned peer MAC. Everything else is
//   dropped silently. Truncated frames and a sop arriving mid-frame pulse
//   rx_arp_err_o.
//
// Ports:
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   rx_data_i      frame data word, first byte in [15:8]
//   rx_vld_i       data/sop/eop/mty valid this cycle (always accepted)
//   rx_sop_i       first word of frame
//   rx_eop_i       last word of frame
//   rx_mty_i       on eop: low byte empty (not needed by the parser)
//   cfg_sip_i      local IP
//   cfg_dip_i      peer IP whose MAC is learned
//   cfg_mac_s_i    local MAC
//   ack_en_o       pulse: ARP request for cfg_sip_i received
//   ack_mac_d_o    requester's sender MAC, held until next ack_en_o
//   ack_ip_d_o     requester's sender IP, held until next ack_en_o
//   arp_mac_vld_o  pulse: ARP reply from cfg_dip_i received
//   arp_mac_o      learned peer MAC, held until next arp_mac_vld_o
//   rx_arp_err_o   pulse: truncated frame or sop mid-frame

module rx_arp #(
   parameter int DATA_W    = 16,
   parameter int IP_W      = 32,
   parameter int MAC_W     = 48,
   parameter int MAX_WORDS = 760
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DATA_W-1:0] rx_data_i,
   input  logic              rx_vld_i,
   input  logic              rx_sop_i,
   input  logic              rx_eop_i,
   input  logic              rx_mty_i,
   input  logic [IP_W-1:0]   cfg_sip_i,
   input  logic [IP_W-1:0]   cfg_dip_i,
   input  logic [MAC_W-1:0]  cfg_mac_s_i,
   output logic              ack_en_o,
   output logic [MAC_W-1:0]  ack_mac_d_o,
   output logic [IP_W-1:0]   ack_ip_d_o,
   output logic              arp_mac_vld_o,
   output logic [MAC_W-1:0]  arp_mac_o,
   output logic              rx_arp_err_o
);

   localparam int            CW      = $clog2(MAX_WORDS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WORDS);
   // Index of the last ARP payload word; an eop before it is a truncation.
   localparam logic [CW-1:0] W_LAST  = CW'(20);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PARSE,
      S_DROP,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;
   // Destination MAC is matched incrementally: bc tracks "all-ones so far",
   // uc tracks "equal to local MAC so far". Either must survive w0-2.
   logic              bc_q, bc_d;
   logic              uc_q, uc_d;
   logic [15:0]       op_q, op_d;
   logic [MAC_W-1:0]  smac_q, smac_d;
   logic [IP_W-1:0]   sip_q, sip_d;
   logic [MAC_W-1:0]  tmac_q, tmac_d;
   logic [IP_W-1:0]   tip_q, tip_d;
   logic [MAC_W-1:0]  ack_mac_hold_q, ack_mac_hold_d;
   logic [IP_W-1:0]   ack_ip_hold_q, ack_ip_hold_d;
   logic [MAC_W-1:0]  arp_mac_hold_q, arp_mac_hold_d;

   logic              take;
   logic              restart;
   logic [CW-1:0]     widx;
   logic              word_ok;
   logic              bc_w;
   logic              req_hit;
   logic              rep_hit;

   // Payload length is implied by the ARP layout; the empty-byte flag
   // carries no information the parser needs.
   logic              unused_mty;
   assign unused_mty = rx_mty_i;

   assign bc_w = (rx_data_i == 16'hFFFF);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         err_q          <= 1'b0;
         bc_q           <= 1'b0;
         uc_q           <= 1'b0;
         op_q           <= '0;
         smac_q         <= '0;
         sip_q          <= '0;
         tmac_q         <= '0;
         tip_q          <= '0;
         ack_mac_hold_q <= '0;
         ack_ip_hold_q  <= '0;
         arp_mac_hold_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         err_q          <= err_d;
         bc_q           <= bc_d;
         uc_q           <= uc_d;
         op_q           <= op_d;
         smac_q         <= smac_d;
         sip_q          <= sip_d;
         tmac_q         <= tmac_d;
         tip_q          <= tip_d;
         ack_mac_hold_q <= ack_mac_hold_d;
         ack_ip_hold_q  <= ack_ip_hold_d;
         arp_mac_hold_q <= arp_mac_hold_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic: word checks, captures, counter, error pulse
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      bc_d    = bc_q;
      uc_d    = uc_q;
      op_d    = op_q;
      smac_d  = smac_q;
      sip_d   = sip_q;
      tmac_d  = tmac_q;
      tip_d   = tip_q;
      word_ok = 1'b1;

      // A word is parsed when it continues a frame in PARSE, or when it is a
      // sop in any state. A sop always restarts at w0.
      take    = rx_vld_i & (rx_sop_i | (state_q == S_PARSE));
      restart = rx_vld_i & rx_sop_i & ((state_q == S_PARSE) | (state_q == S_DROP));
      widx    = rx_sop_i ? '0 : cnt_q;

      if (take) begin
         case (widx)
            CW'(0): begin
               bc_d    = bc_w;
               uc_d    = (rx_data_i == cfg_mac_s_i[47:32]);
               word_ok = bc_d | uc_d;
            end
            CW'(1): begin
               bc_d    = bc_q & bc_w;
               uc_d    = uc_q & (rx_data_i == cfg_mac_s_i[31:16]);
               word_ok = bc_d | uc_d;
            end
            CW'(2): begin
               bc_d    = bc_q & bc_w;
               uc_d    = uc_q & (rx_data_i == cfg_mac_s_i[15:0]);
               word_ok = bc_d | uc_d;
            end
            CW'(6):  word_ok = (rx_data_i == 16'h0806);
            CW'(7):  word_ok = (rx_data_i == 16'h0001);
            CW'(8):  word_ok = (rx_data_i == 16'h0800);
            CW'(9):  word_ok = (rx_data_i == 16'h0604);
            CW'(10): op_d           = rx_data_i;
            CW'(11): smac_d[47:32]  = rx_data_i;
            CW'(12): smac_d[31:16]  = rx_data_i;
            CW'(13): smac_d[15:0]   = rx_data_i;
            CW'(14): sip_d[31:16]   = rx_data_i;
            CW'(15): sip_d[15:0]    = rx_data_i;
            CW'(16): tmac_d[47:32]  = rx_data_i;
            CW'(17): tmac_d[31:16]  = rx_data_i;
            CW'(18): tmac_d[15:0]   = rx_data_i;
            CW'(19): tip_d[31:16]   = rx_data_i;
            CW'(20): tip_d[15:0]    = rx_data_i;
            default: ;
         endcase

         cnt_d = (widx == CNT_MAX) ? CNT_MAX : widx + 1'b1;

         // An eop seen while still parsing is judged on length alone: the
         // header checks of earlier words have all passed by then.
         if (rx_eop_i) begin
            if (widx >= W_LAST) begin
               state_d = S_DONE;
            end else begin
               state_d = S_IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end
         end else if (!word_ok) begin
            state_d = S_DROP;
         end else begin
            state_d = S_PARSE;
         end
      end else if ((state_q == S_DROP) && rx_vld_i && rx_eop_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (state_q == S_DONE) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end

      if (restart) begin
         err_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Output logic: decision in DONE against live cfg values
   // ------------------------------------------------------------------
   always_comb begin
      req_hit = (op_q == 16'd1) && (tip_q == cfg_sip_i);
      rep_hit = (op_q == 16'd2) && (sip_q == cfg_dip_i) && (tmac_q == cfg_mac_s_i);

      ack_en_o      = (state_q == S_DONE) && req_hit;
      arp_mac_vld_o = (state_q == S_DONE) && rep_hit;

      // Fresh values are presented alongside the pulse, then held.
      ack_mac_d_o   = ack_en_o ? smac_q : ack_mac_hold_q;
      ack_ip_d_o    = ack_en_o ? sip_q  : ack_ip_hold_q;
      arp_mac_o     = arp_mac_vld_o ? smac_q : arp_mac_hold_q;

      ack_mac_hold_d = ack_mac_d_o;
      ack_ip_hold_d  = ack_ip_d_o;
      arp_mac_hold_d = arp_mac_o;

      rx_arp_err_o  = err_q;
   end

endmodule

// File: tb/tb_rx_arp.sv
// tb/tb_rx_arp.sv - testbench for rx_arp
module tb_rx_arp;

   localparam logic [31:0] SIP  = 32'hc0a8010a;
   localparam logic [31:0] DIP  = 32'hc0a80109;
   localparam logic [47:0] LMAC = 48'h2c0203040507;
   localparam logic [47:0] BC   = 48'hffffffffffff;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic [15:0] rx_data_i = '0;
   logic        rx_vld_i = 1'b0;
   logic        rx_sop_i = 1'b0;
   logic        rx_eop_i = 1'b0;
   logic        rx_mty_i = 1'b0;
   logic [31:0] cfg_sip_i = SIP;
   logic [31:0] cfg_dip_i = DIP;
   logic [47:0] cfg_mac_s_i = LMAC;
   logic        ack_en_o;
   logic [47:0] ack_mac_d_o;
   logic [31:0] ack_ip_d_o;
   logic        arp_mac_vld_o;
   logic [47:0] arp_mac_o;
   logic        rx_arp_err_o;

   always #5 clk_i = ~clk_i;

   rx_arp dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .rx_data_i    (rx_data_i),
      .rx_vld_i     (rx_vld_i),
      .rx_sop_i     (rx_sop_i),
      .rx_eop_i     (rx_eop_i),
      .rx_mty_i     (rx_mty_i),
      .cfg_sip_i    (cfg_sip_i),
      .cfg_dip_i    (cfg_dip_i),
      .cfg_mac_s_i  (cfg_mac_s_i),
      .ack_en_o     (ack_en_o),
      .ack_mac_d_o  (ack_mac_d_o),
      .ack_ip_d_o   (ack_ip_d_o),
      .arp_mac_vld_o(arp_mac_vld_o),
      .arp_mac_o    (arp_mac_o),
      .rx_arp_err_o (rx_arp_err_o)
   );

   typedef struct {
      logic [47:0] dst;
      logic [15:0] etype, htype, ptype, hp, op;
      logic [47:0] smac;
      logic [31:0] sip;
      logic [47:0] tmac;
      logic [31:0] tip;
      int          n;
      bit          gaps;
   } vec_t;

   typedef struct {
      vec_t v;
      bit   ea, er, ee;   // expected ack / arp reply / error pulse
   } tv_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int          ack_cyc[$];
   logic [47:0] ack_mac[$];
   logic [31:0] ack_ip[$];
   int          arp_cyc[$];
   logic [47:0] arp_mac_l[$];
   int          err_cyc[$];

   always @(negedge clk_i) begin
      if (ack_en_o === 1'b1) begin
         ack_cyc.push_back(cyc);
         ack_mac.push_back(ack_mac_d_o);
         ack_ip.push_back(ack_ip_d_o);
      end
      if (arp_mac_vld_o === 1'b1) begin
         arp_cyc.push_back(cyc);
         arp_mac_l.push_back(arp_mac_o);
      end
      if (rx_arp_err_o === 1'b1) err_cyc.push_back(cyc);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic [47:0] dst, input logic [15:0] op,
                               input logic [47:0] smac, input logic [31:0] sip,
                               input logic [47:0] tmac, input logic [31:0] tip,
                               input int n, input bit gaps);
      vec_t v;
      v.dst = dst; v.etype = 16'h0806; v.htype = 16'h0001; v.ptype = 16'h0800;
      v.hp = 16'h0604; v.op = op; v.smac = smac; v.sip = sip; v.tmac = tmac;
      v.tip = tip; v.n = n; v.gaps = gaps;
      return v;
   endfunction

   function automatic logic [15:0] word_at(input vec_t v, input int i);
      case (i)
         0:  return v.dst[47:32];
         1:  return v.dst[31:16];
         2:  return v.dst[15:0];
         6:  return v.etype;
         7:  return v.htype;
         8:  return v.ptype;
         9:  return v.hp;
         10: return v.op;
         11: return v.smac[47:32];
         12: return v.smac[31:16];
         13: return v.smac[15:0];
         14: return v.sip[31:16];
         15: return v.sip[15:0];
         16: return v.tmac[47:32];
         17: return v.tmac[31:16];
         18: return v.tmac[15:0];
         19: return v.tip[31:16];
         20: return v.tip[15:0];
         default: return 16'($urandom);
      endcase
   endfunction

   // Reference: index of the first header word that disqualifies the frame
   // (99 if none), then the frame-level outcome.
   function automatic int first_bad(input vec_t v);
      bit bc = 1'b1, uc = 1'b1;
      for (int w = 0; w < 3; w++) begin
         bc = bc && (v.dst[47-16*w -: 16] == 16'hffff);
         uc = uc && (v.dst[47-16*w -: 16] == LMAC[47-16*w -: 16]);
         if (!bc && !uc) return w;
      end
      if (v.etype != 16'h0806) return 6;
      if (v.htype != 16'h0001) return 7;
      if (v.ptype != 16'h0800) return 8;
      if (v.hp    != 16'h0604) return 9;
      return 99;
   endfunction

   function automatic void ref_model(input vec_t v, output bit ea, output bit er, output bit ee);
      int f = first_bad(v);
      ea = 0; er = 0; ee = 0;
      if (f < v.n - 1) return;          // dropped before its last word
      if (v.n < 21) begin ee = 1; return; end
      ea = (v.op == 16'd1) && (v.tip == SIP);
      er = (v.op == 16'd2) && (v.sip == DIP) && (v.tmac == LMAC);
   endfunction

   task automatic drive(input logic [15:0] d, input bit sop, input bit eop);
      @(posedge clk_i); #1;
      rx_vld_i = 1'b1; rx_data_i = d; rx_sop_i = sop; rx_eop_i = eop;
      rx_mty_i = eop ? 1'($urandom) : 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i); #1;
         rx_vld_i = 1'b0; rx_sop_i = 1'b0; rx_eop_i = 1'b0; rx_mty_i = 1'b0;
         rx_data_i = 16'($urandom);
      end
   endtask

   task automatic send_frame(input vec_t v, output int sop_c, output int eop_c);
      sop_c = 0; eop_c = 0;
      for (int i = 0; i < v.n; i++) begin
         if (v.gaps && i > 0 && ($urandom % 3 == 0)) idle($urandom_range(1, 2));
         drive(word_at(v, i), i == 0, i == v.n - 1);
         if (i == 0) sop_c = cyc;
         if (i == v.n - 1) eop_c = cyc;
      end
   endtask

   task automatic send_and_check(input string nm, input vec_t v, input bit ea, input bit er, input bit ee);
      int ab = ack_cyc.size(), rb = arp_cyc.size(), eb = err_cyc.size();
      int sc, ec;
      send_frame(v, sc, ec);
      idle(3);
      chk({nm, ".ack_n"}, ack_cyc.size() - ab, ea);
      if (ea && ack_cyc.size() > ab) begin
         chk({nm, ".ack_lat"}, ack_cyc[ab] - ec, 1);
         chk({nm, ".ack_mac"}, ack_mac[ab], v.smac);
         chk({nm, ".ack_ip"}, ack_ip[ab], v.sip);
         chk({nm, ".ack_mac_held"}, ack_mac_d_o, v.smac);
      end
      chk({nm, ".arp_n"}, arp_cyc.size() - rb, er);
      if (er && arp_cyc.size() > rb) begin
         chk({nm, ".arp_lat"}, arp_cyc[rb] - ec, 1);
         chk({nm, ".arp_mac"}, arp_mac_l[rb], v.smac);
         chk({nm, ".arp_mac_held"}, arp_mac_o, v.smac);
      end
      chk({nm, ".err_n"}, err_cyc.size() - eb, ee);
      if (ee && err_cyc.size() > eb) chk({nm, ".err_lat"}, err_cyc[eb] - ec, 1);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".ack_en"}, ack_en_o, 0);
      chk({nm, ".ack_mac_d"}, ack_mac_d_o, 0);
      chk({nm, ".ack_ip_d"}, ack_ip_d_o, 0);
      chk({nm, ".arp_mac_vld"}, arp_mac_vld_o, 0);
      chk({nm, ".arp_mac"}, arp_mac_o, 0);
      chk({nm, ".err"}, rx_arp_err_o, 0);
   endtask

   tv_t  tbl[$];
   vec_t va, vb, vr;
   tv_t  t;
   bit   ea, er, ee;
   int   ab, eb, rb, sa, ea_c, sb, eb_c;

   initial begin
      // Vector table
      t.v = mk(BC, 16'd1, 48'h010203040506, 32'hc0a80109, 48'h0, SIP, 21, 0);
      t.ea = 1; t.er = 0; t.ee = 0; tbl.push_back(t);                       // T1
      t.v = mk(LMAC, 16'd2, 48'h010203040506, 32'hc0a80109, LMAC, SIP, 30, 1);
      t.ea = 0; t.er = 1; t.ee = 0; tbl.push_back(t);                       // T2
      t.v = mk(BC, 16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80109, 48'h0, 32'hc0a8010b, 21, 0);
      t.ea = 0; t.er = 0; t.ee = 0; tbl.push_back(t);                       // T3 wrong target
      t.v = mk(BC, 16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80109, 48'h0, SIP, 30, 0);
      t.v.etype = 16'h0800; tbl.push_back(t);                              // T3 IPv4
      t.v = mk(48'h112233445566, 16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80109, 48'h0, SIP, 30, 0);
      tbl.push_back(t);                                                     // T3 other dst
      t.v = mk(BC, 16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80109, 48'h0, SIP, 13, 0);
      t.ee = 1; tbl.push_back(t);                                           // T4 eop at w12
      t.v = mk(BC, 16'd1, 48'haabbccddeeff, 32'hc0a80164, 48'h0, SIP, 25, 1);
      t.ea = 1; t.ee = 0; tbl.push_back(t);                                 // T4 follow-up
      t.v = mk(BC, 16'd1, 48'h111111222222, 32'hc0a80165, 48'h0, SIP, 800, 0);
      tbl.push_back(t);                                                     // past saturation
      t.v = mk(LMAC, 16'd1, 48'h333333444444, 32'hc0a80166, 48'h0, SIP, 21, 0);
      tbl.push_back(t);                                                     // unicast request
      t.v = mk(LMAC, 16'd2, 48'h555555666666, DIP, 48'h2c0203040508, SIP, 30, 0);
      t.ea = 0; tbl.push_back(t);                                           // reply, wrong tmac
      t.v = mk(BC, 16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80109, 48'h0, SIP, 20, 0);
      t.ee = 1; tbl.push_back(t);                                           // eop at w19
      t.v = mk(BC, 16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80109, 48'h0, SIP, 1, 0);
      tbl.push_back(t);                                                     // sop+eop
      t.v = mk(BC, 16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80109, 48'h0, SIP, 30, 0);
      t.v.htype = 16'h0006; t.ee = 0; tbl.push_back(t);                     // bad htype
      t.v = mk(LMAC, 16'd2, 48'h555555666666, 32'hc0a80199, LMAC, SIP, 30, 0);
      tbl.push_back(t);                                                     // reply, wrong peer
      t.v = mk(BC, 16'd3, 48'h0a0b0c0d0e0f, DIP, LMAC, SIP, 30, 0);
      tbl.push_back(t);                                                     // opcode 3
      t.v = mk(48'hffff03040507, 16'd1, 48'h0a0b0c0d0e0f, DIP, 48'h0, SIP, 30, 0);
      tbl.push_back(t);                                                     // mixed dst

      // Reset state
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk_zero("reset");
      @(posedge clk_i); #1; rst_n_i = 1'b1;
      idle(2);

      foreach (tbl[i]) send_and_check($sformatf("vec%0d", i), tbl[i].v, tbl[i].ea, tbl[i].er, tbl[i].ee);

      // T5a: sop at w8 of a request, then a full request
      va = mk(BC, 16'd1, 48'h0a0a0a0b0b0b, 32'hc0a80170, 48'h0, SIP, 21, 0);
      vb = mk(BC, 16'd1, 48'h0c0c0c0d0d0d, 32'hc0a80171, 48'h0, SIP, 24, 0);
      ab = ack_cyc.size(); eb = err_cyc.size();
      for (int i = 0; i < 8; i++) drive(word_at(va, i), i == 0, 1'b0);
      send_frame(vb, sb, eb_c);
      idle(3);
      chk("t5a.err_n", err_cyc.size() - eb, 1);
      if (err_cyc.size() > eb) chk("t5a.err_lat", err_cyc[eb] - sb, 1);
      chk("t5a.ack_n", ack_cyc.size() - ab, 1);
      if (ack_cyc.size() > ab) begin
         chk("t5a.ack_lat", ack_cyc[ab] - eb_c, 1);
         chk("t5a.ack_mac", ack_mac[ab], vb.smac);
      end

      // T5b: back-to-back requests, second sop in the DONE cycle
      ab = ack_cyc.size(); eb = err_cyc.size();
      send_frame(va, sa, ea_c);
      send_frame(vb, sb, eb_c);
      idle(3);
      chk("t5b.sop_gap", sb - ea_c, 1);
      chk("t5b.ack_n", ack_cyc.size() - ab, 2);
      chk("t5b.err_n", err_cyc.size() - eb, 0);
      if (ack_cyc.size() > ab + 1) begin
         chk("t5b.ack0_lat", ack_cyc[ab] - ea_c, 1);
         chk("t5b.ack0_ip", ack_ip[ab], va.sip);
         chk("t5b.ack1_lat", ack_cyc[ab + 1] - eb_c, 1);
         chk("t5b.ack1_ip", ack_ip[ab + 1], vb.sip);
      end

      // T6: reset for 3 cycles at w15 of a valid request
      ab = ack_cyc.size(); eb = err_cyc.size(); rb = arp_cyc.size();
      for (int i = 0; i < 15; i++) drive(word_at(va, i), i == 0, 1'b0);
      for (int i = 15; i < 18; i++) begin
         drive(word_at(va, i), 1'b0, 1'b0);
         rst_n_i = 1'b0;
      end
      @(negedge clk_i);
      chk_zero("t6.in_reset");
      @(posedge clk_i); #1; rst_n_i = 1'b1;
      for (int i = 18; i < 21; i++) drive(word_at(va, i), 1'b0, i == 20);
      idle(3);
      chk("t6.ack_n", ack_cyc.size() - ab, 0);
      chk("t6.arp_n", arp_cyc.size() - rb, 0);
      chk("t6.err_n", err_cyc.size() - eb, 0);
      chk_zero("t6.after");
      send_and_check("t6.next", vb, 1, 0, 0);

      // Randomized frames against the reference model
      for (int r = 0; r < 40; r++) begin
         case ($urandom % 4)
            0, 1:    vr.dst = BC;
            2:       vr.dst = LMAC;
            default: vr.dst = {16'($urandom), 32'($urandom)};
         endcase
         vr.etype = ($urandom % 8 == 0) ? 16'h0800 : 16'h0806;
         vr.htype = ($urandom % 10 == 0) ? 16'h0006 : 16'h0001;
         vr.ptype = ($urandom % 10 == 0) ? 16'h86dd : 16'h0800;
         vr.hp    = ($urandom % 10 == 0) ? 16'h0610 : 16'h0604;
         vr.op    = 16'($urandom_range(1, 3));
         vr.smac  = {16'($urandom), 32'($urandom)};
         vr.sip   = ($urandom % 2 == 0) ? DIP : 32'($urandom);
         vr.tmac  = ($urandom % 2 == 0) ? LMAC : {16'($urandom), 32'($urandom)};
         vr.tip   = ($urandom % 2 == 0) ? SIP : 32'($urandom);
         vr.n     = ($urandom % 5 == 0) ? int'($urandom_range(1, 20)) : int'($urandom_range(21, 40));
         vr.gaps  = 1'($urandom);
         ref_model(vr, ea, er, ee);
         send_and_check($sformatf("rnd%0d", r), vr, ea, er, ee);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
